// File: rtl/spi_master_if.sv
// spi_master_if: bundles the request handshake and SPI pins of spi_master.
//   Request side : i_start, i_rw, i_addr[15:0], i_wdata[15:0] -> o_busy, o_done, o_rdata[7:0]
//   SPI pins     : o_sck, o_mosi, o_cs (active low), i_miso
// modport master is the spi_master side; modport slave is the requester / SPI slave side.
interface spi_master_if;
  logic        i_start;
  logic        i_rw;
  logic [15:0] i_addr;
  logic [15:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_rdata;
  logic        o_sck;
  logic        o_mosi;
  logic        i_miso;
  logic        o_cs;

  modport master (
    input  i_start, i_rw, i_addr, i_wdata, i_miso,
    output o_busy, o_done, o_rdata, o_sck, o_mosi, o_cs
  );

  modport slave (
    output i_start, i_rw, i_addr, i_wdata, i_miso,
    input  o_busy, o_done, o_rdata, o_sck, o_mosi, o_cs
  );
endinterface

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master issuing fixed 5-byte memory frames.
//   Write frame: 02 ADDR[15:8] ADDR[7:0] WDATA[15:8] WDATA[7:0]
//   Read frame : 03 ADDR[15:8] ADDR[7:0] 00 00, byte 5 from MISO lands in o_rdata.
// Ports:
//   i_clk   - system clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   bus     - spi_master_if.master (request handshake + SPI pins)
// Parameters:
//   CLK_DIV    - SCK half-period in i_clk cycles (2..255)
//   GAP_CYCLES - idle cycles between bytes, SCK low, CS asserted (1..255)
module spi_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input logic         i_clk,
  input logic         i_rst_n,
  spi_master_if.master bus
);

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StGap, StHold, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic        sck_q, sck_d;
  logic        rw_q, rw_d;
  logic [39:0] sr_q, sr_d;    // outgoing frame, MSB drives MOSI
  logic [7:0]  rx_q, rx_d;    // incoming bits, last 8 are byte 5
  logic [7:0]  rdata_q, rdata_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sck_q   <= 1'b0;
      rw_q    <= 1'b0;
      sr_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sck_q   <= sck_d;
      rw_q    <= rw_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sck_d   = sck_q;
    rw_d    = rw_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          state_d = StSetup;
          rw_d    = bus.i_rw;
          sr_d    = {(bus.i_rw ? 8'h02 : 8'h03), bus.i_addr, (bus.i_rw ? bus.i_wdata : 16'h0000)};
          div_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          sck_d   = 1'b0;
          rx_d    = '0;
        end
      end
      StSetup: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          state_d = StShift;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StShift: begin
        if (div_q != DivLast) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (!sck_q) begin
            // Rising SCK edge: sample MISO on the same i_clk edge.
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], bus.i_miso};
          end else begin
            // Falling SCK edge: next bit appears on MOSI while SCK is low.
            sck_d = 1'b0;
            sr_d  = {sr_q[38:0], 1'b0};
            if (bit_q == 3'd7) begin
              bit_d = '0;
              if (byte_q == 3'd4) begin
                state_d = StHold;
              end else begin
                byte_d  = byte_q + 3'd1;
                state_d = StGap;
              end
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
      end
      StGap: begin
        if (div_q == GapLast) begin
          div_d   = '0;
          state_d = StShift;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StHold: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          state_d = StDone;
          // Loaded here so o_rdata is already valid while o_done is high.
          if (!rw_q) rdata_d = rx_q;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StDone: begin
        // i_start is deliberately not looked at in this state.
        state_d = StIdle;
        byte_d  = '0;
        bit_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  logic cs_active;
  assign cs_active = (state_q == StSetup) || (state_q == StShift) ||
                     (state_q == StGap)   || (state_q == StHold);

  assign bus.o_cs    = ~cs_active;
  assign bus.o_sck   = sck_q;
  assign bus.o_mosi  = cs_active & sr_q[39];
  assign bus.o_busy  = (state_q != StIdle);
  assign bus.o_done  = (state_q == StDone);
  assign bus.o_rdata = rdata_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in i_clk cycles (legal values 2..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 8: inter-byte idle cycles with SCK low and CS asserted (legal values 1..255).
REQ-003 SHALL have port i_clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_start, input, 1: transaction request, sampled only while o_busy=0.
REQ-006 SHALL have port i_rw, input, 1: 1 = write transaction, 0 = read transaction.
REQ-007 SHALL have port i_addr, input, 16: target memory address.
REQ-008 SHALL have port i_wdata, input, 16: write data word, sent MSB byte first.
REQ-009 SHALL have port o_busy, output, 1: transaction in progress.
REQ-010 SHALL have port o_done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port o_rdata, output, 8: byte read by the last read transaction.
REQ-012 SHALL have port o_sck, output, 1: SPI clock, mode 0 (idles low).
REQ-013 SHALL have port o_mosi, output, 1: serial data to the slave.
REQ-014 SHALL have port i_miso, input, 1: serial data from the slave.
REQ-015 SHALL have port o_cs, output, 1: slave select, active low.

Function
REQ-016 SHALL capture i_rw, i_addr and i_wdata on the rising edge where i_start=1 and o_busy=0 (edge T0); i_start while o_busy=1 SHALL be ignored.
REQ-017 SHALL always send a 5-byte frame, MSB first:
- Write: 0x02, ADDR[15:8], ADDR[7:0], WDATA[15:8], WDATA[7:0].
- Read: 0x03, ADDR[15:8], ADDR[7:0], 0x00 (dummy byte), 0x00 (data byte).
REQ-018 SHALL implement the state machine IDLE -> SETUP -> SHIFT -> GAP -> SHIFT ... -> HOLD -> DONE -> IDLE.
- GAP is entered after bytes 1-4.
- HOLD is entered after byte 5.
REQ-019 SHALL assert o_cs=0 and o_busy=1 from T0+1; SETUP SHALL last CLK_DIV cycles with o_sck=0 and o_mosi equal to bit 7 of byte 1.
REQ-020 SHALL give each bit 2*CLK_DIV cycles: o_sck low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-021 SHALL update o_mosi only while o_sck is low, at the start of each bit period.
REQ-022 SHALL sample i_miso on the i_clk edge where o_sck rises.
REQ-023 SHALL hold o_sck=0 during GAP for GAP_CYCLES cycles, with o_mosi presenting bit 7 of the next byte.
REQ-024 SHALL hold o_sck=0 and o_cs=0 during HOLD for CLK_DIV cycles.
REQ-025 SHALL, in DONE (one cycle), drive o_cs=1, o_done=1 and o_busy=1; o_busy SHALL be 0 on the following cycle, when a new i_start may be accepted.
REQ-026 SHALL keep o_cs low for exactly CLK_DIV + 80*CLK_DIV + 4*GAP_CYCLES + CLK_DIV cycles (360 at defaults).
REQ-027 SHALL load o_rdata with the 8 bits sampled during byte 5 of a read, updating it in the DONE cycle.
REQ-028 SHALL leave o_rdata unchanged by write transactions.
REQ-029 SHALL, in IDLE, drive o_sck=0, o_mosi=0, o_cs=1, o_done=0.
REQ-030 SHALL use bit counter 0..7, byte counter 0..4 and divider counter 0..max(CLK_DIV,GAP_CYCLES)-1, none of which may wrap outside these ranges.
REQ-031 SHALL ignore i_start asserted in the DONE cycle.

Reset
REQ-032 SHALL, while i_rst_n=0 (asynchronous, at any point including mid-frame), force state=IDLE, o_cs=1, o_sck=0, o_mosi=0, o_busy=0, o_done=0, o_rdata=0x00, and clear all counters and captured registers.
REQ-033 SHALL accept i_start on the first rising edge after i_rst_n deasserts.
REQ-034 SHALL never issue a partial frame after a reset; the aborted frame is simply truncated by o_cs rising.

Verification
REQ-035 Write at defaults: i_rw=1, i_addr=0x1234, i_wdata=0xBEEF -> MOSI bytes 02 12 34 BE EF, 40 SCK rising edges, o_cs low exactly 360 cycles, single o_done pulse, o_rdata unchanged.
REQ-036 Read: i_rw=0, i_addr=0x0A05, slave model drives 0xA5 on MISO in byte 5 -> MOSI bytes 03 0A 05 00 00, o_rdata=0xA5 in the DONE cycle.
REQ-037 Busy rejection: second i_start pulses during the frame and in the DONE cycle -> no effect, exactly one frame; i_start on the cycle after DONE -> new frame starts.
REQ-038 Mid-frame reset: i_rst_n=0 during byte 3 -> o_cs=1, o_sck=0, o_busy=0 immediately (asynchronously); after release, a read of 0x0001 completes normally.
REQ-039 Timing: CLK_DIV=2, GAP_CYCLES=1 -> o_cs low for 2+160+4+2=168 cycles; SCK high/low 2 cycles each; MOSI never toggles while SCK=1.
REQ-040 Back-to-back reads returning 0x3C then 0xC3 -> o_rdata=0x3C after the first frame and 0xC3 after the second; o_cs high for at least 1 cycle between frames.
